res_ram_arbiter: RTL and testbench
==================================

Name: res_ram_arbiter

Overview:
- Two-client arbiter sharing the single res_RAM port (16384 x 8, read sampled at negedge, write at posedge) between requesters, e.g. the sti loader/unpacker (client 0) and the DT forward/backward pass engine (client 1).
- Round-robin arbitration, optional lock for read-modify-write sequences, fixed read latency, registered RAM-side outputs.

Parameters:
ADDR_W, 14, res_RAM address width
DATA_W, 8, res_RAM data width
MAX_LOCK, 8, max consecutive locked grants before forced release (1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
c0_req  input  1  client 0 request valid
c0_wr  input  1  client 0: 1 = write, 0 = read
c0_lock  input  1  client 0 requests to keep grant next cycle
c0_addr  input  ADDR_W  client 0 address
c0_wdata  input  DATA_W  client 0 write data
c0_gnt  output  1  client 0 request accepted this cycle (combinational)
c0_rvalid  output  1  client 0 read data valid (1-cycle pulse)
c0_rdata  output  DATA_W  client 0 read data
c1_*  same set as c0_* for client 1
res_rd  output  1  RAM read enable
res_wr  output  1  RAM write enable
res_addr  output  ADDR_W  RAM address
res_do  output  DATA_W  RAM write data
res_di  input  DATA_W  RAM read data

Behaviour:
- Reset values: res_rd=0, res_wr=0, res_addr=0, res_do=0, cN_rvalid=0, cN_rdata=0, last-grant pointer=1 (client 0 wins first tie), lock count=0, lock owner=none. cN_gnt forced 0 while reset high.
- Handshake: transaction accepted at the posedge ending a cycle with cN_req=1 and cN_gnt=1. Client holds req/wr/addr/wdata stable until gnt. At most one gnt per cycle.
- Arbitration (combinational): only one req -> grant it. Both req -> grant client != last-grant pointer. Pointer updates to the granted client on each accept.
- Lock: if accepted client had lock=1, it becomes lock owner; next cycle the other client is masked while the owner has req=1. Owner dropping req or lock releases lock immediately (that cycle arbitrates normally). Lock count increments per locked accept; when count reaches MAX_LOCK, the lock is ignored for the following cycle (other client, if requesting, wins), count clears.
- RAM side (registered at accept edge, cycle k = accept cycle): cycle k+1 drives res_wr or res_rd =1 with res_addr/res_do from the client; no accept -> res_rd=res_wr=0, res_addr/res_do hold last value.
- Write: RAM commits at end of cycle k+1. No response to client.
- Read: RAM updates res_di at negedge of cycle k+1; arbiter registers res_di into requester's cN_rdata at end of k+1; cN_rvalid=1 during cycle k+2 only. Latency 2 cycles, fixed. cN_rdata holds until next read for that client.
- Back-to-back: one accept per cycle sustained (throughput 1). Write at k then read same address at k+1 returns new data (write commits before the read negedge); no forwarding needed.
- Read tag: 1-bit in-flight owner register per pipeline stage; rvalid routed only to the issuing client.
- Reset mid-operation: all in-flight transactions dropped, no rvalid, pending write not issued if not yet driven, pointer/lock reinitialised.
- Simultaneous: client's own rvalid and a new gnt in the same cycle are legal and independent.

Decomposition:
- Package res_arb_pkg: ADDR_W/DATA_W defaults, client-id constants CLI0=0/CLI1=1, MAX_LOCK default.
- One sub-module rr_arb2: 2-way round-robin pointer plus lock owner/counter logic, outputs gnt[1:0]; parent holds RAM-side registers and read-return pipeline.

Test Plan:
- c0 writes 8'h01 to addr 14'h0000, then c0 reads 14'h0000 next cycle -> res_wr high 1 cycle after accept, c0_rvalid two cycles after read accept with c0_rdata=8'h01, c1_rvalid stays 0.
- Both req continuously with lock=0, reads to 14'h0010 (c0) / 14'h0020 (c1) -> grants alternate c0,c1,c0,...; first grant c0 after reset; every cycle one res_rd.
- c1 req+lock for 20 cycles while c0 also requesting, MAX_LOCK=8 -> c1 gets 8 consecutive grants, c0 granted on 9th cycle, then c1 locks again for 8.
- Interleaved writes/reads at 14'h3FFF (top address) by both clients with data 8'hA5/8'h5A -> each client's rdata returns the last value written before its read accept; no address wrap or truncation.
- Assert reset for 1 cycle while c1 read in flight (cycle k+1) -> no c1_rvalid, all outputs 0, first post-reset tie granted to c0.
- Single client c0 req for 1 cycle then idle -> exactly one res_rd pulse; res_addr holds value afterwards with res_rd=res_wr=0.

Source files
------------

// File: rtl/res_arb_pkg.sv
// Shared constants for the res_RAM two-client arbiter.
package res_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 14;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_MAX_LOCK = 8;

  // Width of the locked-grant run counter; covers MAX_LOCK up to 255.
  localparam int unsigned LOCK_CNT_W   = 8;

  // Client identifiers; also the index into the grant vector.
  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

endpackage : res_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a bounded grant lock for
// read-modify-write sequences. The grant is combinational; pointer, lock
// owner and run counter advance on the accepting edge.
module rr_arb2
  import res_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int unsigned CNT_W = LOCK_CNT_W;

  logic             last;     // client granted most recently
  logic             own_vld;  // a lock owner exists
  logic             own;      // lock owner id
  logic [CNT_W-1:0] cnt;      // consecutive locked accepts of the owner

  logic             rel_now;  // run limit reached: lock ignored this cycle
  logic             hold;     // owner keeps the port this cycle
  logic             acc;
  logic             gid;

  // Lock is honoured only while the owner still requests with lock set.
  always_comb begin
    rel_now = (cnt == CNT_W'(MAX_LOCK));
    hold    = own_vld && !rel_now && req[own] && lock[own];
  end

  // Grant selection; suppressed entirely while reset is high.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (hold) begin
        gnt[own] = 1'b1;
      end else if (req == 2'b11) begin
        gnt[~last] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    acc = |gnt;
    gid = gnt[1];
  end

  // Pointer, lock owner and run counter update on each clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last    <= CLI1;
      own_vld <= 1'b0;
      own     <= CLI0;
      cnt     <= '0;
    end else begin
      if (acc) begin
        last <= gid;
      end
      if (acc && lock[gid]) begin
        own_vld <= 1'b1;
        own     <= gid;
        // A new owner, or a run that just hit the limit, starts over at one.
        if (own_vld && (own == gid) && !rel_now) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          cnt <= CNT_W'(1);
        end
      end else begin
        own_vld <= 1'b0;
        cnt     <= '0;
      end
    end
  end

endmodule : rr_arb2

// File: rtl/res_ram_arbiter.sv
// Shares the single res_RAM port between two clients. RAM-side controls are
// registered one cycle after accept; read data returns to the issuing
// client two cycles after accept.
module res_ram_arbiter
  import res_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              c0_req,
  input  logic              c0_wr,
  input  logic              c0_lock,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,

  input  logic              c1_req,
  input  logic              c1_wr,
  input  logic              c1_lock,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,

  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);

  logic [1:0]        gnt;
  logic              acc;
  logic              gid;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_tag;   // issuing client of the read on the RAM port

  rr_arb2 #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({c1_req, c0_req}),
    .lock  ({c1_lock, c0_lock}),
    .gnt   (gnt)
  );

  assign c0_gnt = gnt[0];
  assign c1_gnt = gnt[1];

  // Select the granted client's command.
  always_comb begin
    acc       = |gnt;
    gid       = gnt[1];
    sel_wr    = (gid == CLI1) ? c1_wr    : c0_wr;
    sel_addr  = (gid == CLI1) ? c1_addr  : c0_addr;
    sel_wdata = (gid == CLI1) ? c1_wdata : c0_wdata;
  end

  // RAM command stage: strobes last one cycle, address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
      rd_tag   <= CLI0;
    end else begin
      res_rd <= acc && !sel_wr;
      res_wr <= acc && sel_wr;
      if (acc) begin
        res_addr <= sel_addr;
        res_do   <= sel_wdata;
        rd_tag   <= gid;
      end
    end
  end

  // Read return stage: capture RAM data for the tagged client only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
      c0_rdata  <= '0;
      c1_rdata  <= '0;
    end else begin
      c0_rvalid <= res_rd && (rd_tag == CLI0);
      c1_rvalid <= res_rd && (rd_tag == CLI1);
      if (res_rd && (rd_tag == CLI0)) begin
        c0_rdata <= res_di;
      end
      if (res_rd && (rd_tag == CLI1)) begin
        c1_rdata <= res_di;
      end
    end
  end

endmodule : res_ram_arbiter

// File: tb/tb_res_ram_arbiter.sv
// Scoreboard bench for res_ram_arbiter: command queues drive both clients,
// a negedge monitor predicts grants, RAM strobes and read returns.
`timescale 1ns/1ps
module tb_res_ram_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned ML = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_req, c0_wr, c0_lock, c1_req, c1_wr, c1_lock;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic          res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do;
  logic [DW-1:0] res_di = '0;

  res_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_lock(c0_lock), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_lock(c1_lock), .c1_addr(c1_addr),
    .c1_wdata(c1_wdata), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
  );

  always #5 clk = ~clk;

  // res_RAM: read sampled at negedge, write committed at posedge.
  logic [DW-1:0] ram [0:16383];
  always @(negedge clk) if (res_rd) res_di <= ram[res_addr];
  always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus: per-client command queues ----------------
  typedef struct {
    bit            wr;
    bit            lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
  } cmd_t;

  cmd_t cq0[$], cq1[$];
  cmd_t cur0, cur1;
  bit   have0 = 0, have1 = 0, acc0 = 0, acc1 = 0;

  function automatic cmd_t mk(bit wr, bit lk, logic [AW-1:0] a, logic [DW-1:0] d, int gap);
    cmd_t c;
    c.wr = wr; c.lock = lk; c.addr = a; c.wdata = d; c.gap = gap;
    return c;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 14'h0000;
      1: return 14'h0010;
      2: return 14'h0020;
      3: return 14'h3FFF;
      default: return AW'($urandom);
    endcase
  endfunction

  // One cycle: note accepts, then present the next command after the edge.
  task automatic step();
    @(negedge clk);
    acc0 = c0_req && c0_gnt && !reset;
    acc1 = c1_req && c1_gnt && !reset;
    @(posedge clk);
    #1;
    if (have0 && acc0) have0 = 0;
    if (!have0 && cq0.size() > 0) begin cur0 = cq0.pop_front(); have0 = 1; end
    if (have0 && cur0.gap > 0) begin cur0.gap--; c0_req = 0; end
    else if (have0) begin
      c0_req = 1; c0_wr = cur0.wr; c0_lock = cur0.lock;
      c0_addr = cur0.addr; c0_wdata = cur0.wdata;
    end else c0_req = 0;
    if (have1 && acc1) have1 = 0;
    if (!have1 && cq1.size() > 0) begin cur1 = cq1.pop_front(); have1 = 1; end
    if (have1 && cur1.gap > 0) begin cur1.gap--; c1_req = 0; end
    else if (have1) begin
      c1_req = 1; c1_wr = cur1.wr; c1_lock = cur1.lock;
      c1_addr = cur1.addr; c1_wdata = cur1.wdata;
    end else c1_req = 0;
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((have0 || have1 || cq0.size() > 0 || cq1.size() > 0) && n < budget) begin
      step();
      n++;
    end
    n_assert++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
    end
    repeat (4) step();
  endtask

  // ---------------- reference model and monitor ----------------
  typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;
  rd_exp_t q0[$], q1[$];

  logic [DW-1:0] shadow [0:16383];
  int            cyc = 0;
  int            m_last = 1;     // last granted client
  int            m_own = -1;     // client holding a lock run, -1 none
  int            m_run = 0;      // length of the current locked run
  bit            op_vld = 0, op_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] op_data = '0;
  logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;

  always @(negedge clk) begin
    bit   rq [2];
    bit   lk [2];
    int   eg;
    rd_exp_t e;
    bit   exp_v;
    cyc++;
    if (reset) begin
      chk("rst_c0_gnt", c0_gnt, 0);       chk("rst_c1_gnt", c1_gnt, 0);
      chk("rst_res_rd", res_rd, 0);       chk("rst_res_wr", res_wr, 0);
      chk("rst_res_addr", res_addr, 0);   chk("rst_res_do", res_do, 0);
      chk("rst_c0_rvalid", c0_rvalid, 0); chk("rst_c1_rvalid", c1_rvalid, 0);
      chk("rst_c0_rdata", c0_rdata, 0);   chk("rst_c1_rdata", c1_rdata, 0);
      q0.delete(); q1.delete();
      m_last = 1; m_own = -1; m_run = 0; op_vld = 0; op_wr = 0;
      m_addr = '0; last_rd0 = '0; last_rd1 = '0;
    end else begin
      // RAM side: the command accepted last cycle appears now.
      chk("res_rd", res_rd, op_vld && !op_wr);
      chk("res_wr", res_wr, op_vld && op_wr);
      chk("res_addr", res_addr, m_addr);
      if (op_vld && op_wr) chk("res_do", res_do, op_data);

      // Read returns, exactly two cycles after the read was accepted.
      exp_v = (q0.size() > 0) && (q0[0].due == cyc);
      chk("c0_rvalid", c0_rvalid, exp_v);
      if (exp_v) begin e = q0.pop_front(); last_rd0 = e.data; end
      chk("c0_rdata", c0_rdata, last_rd0);
      exp_v = (q1.size() > 0) && (q1[0].due == cyc);
      chk("c1_rvalid", c1_rvalid, exp_v);
      if (exp_v) begin e = q1.pop_front(); last_rd1 = e.data; end
      chk("c1_rdata", c1_rdata, last_rd1);

      // Arbitration: a locked run shorter than ML keeps the port,
      // otherwise ties go to the client that did not win last.
      rq[0] = c0_req; rq[1] = c1_req; lk[0] = c0_lock; lk[1] = c1_lock;
      if (m_own >= 0 && m_run < int'(ML) && rq[m_own] && lk[m_own]) eg = m_own;
      else if (rq[0] && rq[1]) eg = 1 - m_last;
      else if (rq[0]) eg = 0;
      else if (rq[1]) eg = 1;
      else eg = -1;
      chk("c0_gnt", c0_gnt, eg == 0);
      chk("c1_gnt", c1_gnt, eg == 1);

      op_vld = (eg >= 0);
      if (eg >= 0) begin
        m_last  = eg;
        op_wr   = (eg == 0) ? c0_wr : c1_wr;
        m_addr  = (eg == 0) ? c0_addr : c1_addr;
        op_data = (eg == 0) ? c0_wdata : c1_wdata;
        if (lk[eg]) begin
          m_run = (m_own == eg && m_run < int'(ML)) ? m_run + 1 : 1;
          m_own = eg;
        end else begin
          m_own = -1; m_run = 0;
        end
        if (op_wr) shadow[m_addr] = op_data;
        else begin
          e.due = cyc + 2; e.data = shadow[m_addr];
          if (eg == 0) q0.push_back(e); else q1.push_back(e);
        end
      end else begin
        op_wr = 0; m_own = -1; m_run = 0;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < 16384; i++) begin ram[i] = '0; shadow[i] = '0; end
    reset = 1'b1;
    c0_req = 0; c0_wr = 0; c0_lock = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_wr = 0; c1_lock = 0; c1_addr = '0; c1_wdata = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Write then immediate read-back by client 0.
    cq0.push_back(mk(1, 0, 14'h0000, 8'h01, 0));
    cq0.push_back(mk(0, 0, 14'h0000, 8'h00, 0));
    run_idle("wr_rd", 50);

    // Continuous contention without lock: alternating grants.
    for (int i = 0; i < 10; i++) begin
      cq0.push_back(mk(0, 0, 14'h0010, 8'h00, 0));
      cq1.push_back(mk(0, 0, 14'h0020, 8'h00, 0));
    end
    run_idle("rr", 100);

    // Client 1 locks continuously against a requesting client 0.
    for (int i = 0; i < 20; i++) begin
      cq1.push_back(mk(0, 1, 14'h0020, 8'h00, 0));
      cq0.push_back(mk(0, 0, 14'h0010, 8'h00, 0));
    end
    run_idle("lock", 200);

    // Interleaved traffic at the top address.
    cq0.push_back(mk(1, 0, 14'h3FFF, 8'hA5, 0));
    cq0.push_back(mk(0, 0, 14'h3FFF, 8'h00, 0));
    cq0.push_back(mk(0, 0, 14'h3FFF, 8'h00, 1));
    cq1.push_back(mk(0, 0, 14'h3FFF, 8'h00, 0));
    cq1.push_back(mk(1, 0, 14'h3FFF, 8'h5A, 0));
    cq1.push_back(mk(0, 0, 14'h3FFF, 8'h00, 0));
    run_idle("top", 100);

    // Reset while a client 1 read is on the RAM port.
    cq1.push_back(mk(0, 0, 14'h0010, 8'h00, 0));
    n = 0;
    do begin step(); n++; end while (!acc1 && n < 50);
    n_assert++;
    if (!acc1) begin n_fail++; $display("FAIL rst_mid_accept: c1 read not accepted in %0d cycles", n); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cq0.push_back(mk(0, 0, 14'h3FFF, 8'h00, 0));
    cq1.push_back(mk(0, 0, 14'h3FFF, 8'h00, 0));
    run_idle("post_rst", 50);

    // Single read, then idle: address must hold with strobes low.
    cq0.push_back(mk(0, 0, 14'h1234, 8'h00, 0));
    run_idle("single", 50);
    repeat (4) step();

    // Randomized mixed traffic with locks and gaps.
    for (int i = 0; i < 300; i++) begin
      cq0.push_back(mk(1'($urandom), ($urandom_range(0, 3) == 0), pick_addr(),
                       DW'($urandom), $urandom_range(0, 2)));
      cq1.push_back(mk(1'($urandom), ($urandom_range(0, 3) == 0), pick_addr(),
                       DW'($urandom), $urandom_range(0, 2)));
    end
    run_idle("random", 4000);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_res_ram_arbiter
